// File: rtl/display_pkg.sv
// Shared display-path definitions: BCD digit type, digit limits, counter modes
// and a helper that clamps an arbitrary nibble into the legal BCD range.
package display_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BCD_MAX = 4'd9;
  localparam digit_t BCD_MIN = 4'd0;

  localparam int unsigned MODE_SAT  = 0;
  localparam int unsigned MODE_WRAP = 1;

  // Force non-decimal nibbles (A..F) to 9 so a digit never holds > 9.
  function automatic digit_t bcd_clamp(input digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple counter: computes the digit's next value for an
// increment or decrement step and the carry/borrow passed to the next digit.
// Ports:
//   digit_i      current digit value
//   inc, dec     counter is stepping up / down this cycle (mutually exclusive)
//   carry_in     lower digits roll over (tie high on digit 0)
//   borrow_in    lower digits roll under (tie high on digit 0)
//   carry_out_c  this digit rolls 9 -> 0 while incrementing
//   borrow_out_c this digit rolls 0 -> 9 while decrementing
//   next_c       next digit value (equals digit_i when not stepping)
module bcd_digit
  import display_pkg::*;
(
  input  digit_t digit_i,
  input  logic   inc,
  input  logic   dec,
  input  logic   carry_in,
  input  logic   borrow_in,
  output logic   carry_out_c,
  output logic   borrow_out_c,
  output digit_t next_c
);

  // Single-digit step with rollover.
  always_comb begin
    next_c       = digit_i;
    carry_out_c  = 1'b0;
    borrow_out_c = 1'b0;
    if (inc && carry_in) begin
      if (digit_i >= BCD_MAX) begin
        next_c      = BCD_MIN;
        carry_out_c = 1'b1;
      end else begin
        next_c = digit_i + 4'd1;
      end
    end else if (dec && borrow_in) begin
      if (digit_i == BCD_MIN) begin
        next_c       = BCD_MAX;
        borrow_out_c = 1'b1;
      end else begin
        next_c = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit up/down BCD event counter for the display path, with saturate or
// wrap behaviour at the limits, synchronous clear/load/hold and status flags.
// Ports:
//   clk, reset_n  clock (rising edge), asynchronous active-low reset
//   clear         synchronous clear to zero (also clears sat)
//   load,load_val synchronous load of packed BCD value, bad nibbles -> 9
//   hold          blocks up/down counting
//   up, down      one count per cycle high; both high means no change
//   count         packed BCD count, digit 0 in bits [3:0]
//   at_max,at_min count is all 9s / all 0s
//   wrap_tick     one-cycle pulse after a wrap event
//   sat           sticky flag: an event was dropped at a limit
module bcd_counter_n
  import display_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WRAP   = MODE_SAT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      hold,
  input  logic                      up,
  input  logic                      down,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      at_max,
  output logic                      at_min,
  output logic                      wrap_tick,
  output logic                      sat
);

  localparam int unsigned W = DIGIT_W * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

  logic [W-1:0] count_q, count_d;
  logic         at_max_q, at_max_d;
  logic         at_min_q, at_min_d;
  logic         wrap_tick_q, wrap_tick_d;
  logic         sat_q, sat_d;

  logic          up_only_c;
  logic          down_only_c;
  logic [DIGITS:0] carry_c;
  logic [DIGITS:0] borrow_c;
  logic [W-1:0]  step_c;
  logic          limit_c;

  assign up_only_c   = up & ~down & ~hold;
  assign down_only_c = down & ~up & ~hold;

  // Digit 0 always steps; higher digits step only on ripple carry/borrow.
  assign carry_c[0]  = 1'b1;
  assign borrow_c[0] = 1'b1;

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    bcd_digit u_digit (
      .digit_i      (count_q[DIGIT_W*i +: DIGIT_W]),
      .inc          (up_only_c),
      .dec          (down_only_c),
      .carry_in     (carry_c[i]),
      .borrow_in    (borrow_c[i]),
      .carry_out_c  (carry_c[i+1]),
      .borrow_out_c (borrow_c[i+1]),
      .next_c       (step_c[DIGIT_W*i +: DIGIT_W])
    );
  end

  // Ripple out of the top digit means the step crossed all-9s or all-0s.
  assign limit_c = carry_c[DIGITS] | borrow_c[DIGITS];

  // Next-state: clear > load > (hold / up / down via step_c).
  always_comb begin
    count_d     = count_q;
    sat_d       = sat_q;
    wrap_tick_d = 1'b0;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (load) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        count_d[DIGIT_W*i +: DIGIT_W] = bcd_clamp(load_val[DIGIT_W*i +: DIGIT_W]);
      end
    end else if (limit_c) begin
      if (WRAP == MODE_WRAP) begin
        count_d     = step_c;
        wrap_tick_d = 1'b1;
      end else begin
        sat_d = 1'b1;
      end
    end else begin
      count_d = step_c;
    end
    at_max_d = (count_d == ALL_NINES);
    at_min_d = (count_d == '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      at_max_q    <= 1'b0;
      at_min_q    <= 1'b1;
      wrap_tick_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      at_max_q    <= at_max_d;
      at_min_q    <= at_min_d;
      wrap_tick_q <= wrap_tick_d;
      sat_q       <= sat_d;
    end
  end

  assign count     = count_q;
  assign at_max    = at_max_q;
  assign at_min    = at_min_q;
  assign wrap_tick = wrap_tick_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: six instances (1/4/8 digits, saturate and
// wrap) share control inputs; expected values are hand-computed constants.
module tb_bcd_counter_n;

  logic clk = 1'b0;
  logic reset_n, clear, load, hold, up, down;
  logic [15:0] lv4;
  logic [3:0]  lv1;
  logic [31:0] lv8;

  logic [15:0] c4s, c4w;
  logic [3:0]  c1s, c1w;
  logic [31:0] c8s, c8w;
  logic mx4s, mn4s, wt4s, st4s, mx4w, mn4w, wt4w, st4w;
  logic mx1s, mn1s, wt1s, st1s, mx1w, mn1w, wt1w, st1w;
  logic mx8s, mn8s, wt8s, st8s, mx8w, mn8w, wt8w, st8w;

  int tests_run = 0;
  int tests_failed = 0;
  logic bad_bcd = 1'b0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4), .WRAP(0)) u_d4s (.clk(clk), .reset_n(reset_n), .clear(clear),
    .load(load), .load_val(lv4), .hold(hold), .up(up), .down(down), .count(c4s),
    .at_max(mx4s), .at_min(mn4s), .wrap_tick(wt4s), .sat(st4s));
  bcd_counter_n #(.DIGITS(4), .WRAP(1)) u_d4w (.clk(clk), .reset_n(reset_n), .clear(clear),
    .load(load), .load_val(lv4), .hold(hold), .up(up), .down(down), .count(c4w),
    .at_max(mx4w), .at_min(mn4w), .wrap_tick(wt4w), .sat(st4w));
  bcd_counter_n #(.DIGITS(1), .WRAP(0)) u_d1s (.clk(clk), .reset_n(reset_n), .clear(clear),
    .load(load), .load_val(lv1), .hold(hold), .up(up), .down(down), .count(c1s),
    .at_max(mx1s), .at_min(mn1s), .wrap_tick(wt1s), .sat(st1s));
  bcd_counter_n #(.DIGITS(1), .WRAP(1)) u_d1w (.clk(clk), .reset_n(reset_n), .clear(clear),
    .load(load), .load_val(lv1), .hold(hold), .up(up), .down(down), .count(c1w),
    .at_max(mx1w), .at_min(mn1w), .wrap_tick(wt1w), .sat(st1w));
  bcd_counter_n #(.DIGITS(8), .WRAP(0)) u_d8s (.clk(clk), .reset_n(reset_n), .clear(clear),
    .load(load), .load_val(lv8), .hold(hold), .up(up), .down(down), .count(c8s),
    .at_max(mx8s), .at_min(mn8s), .wrap_tick(wt8s), .sat(st8s));
  bcd_counter_n #(.DIGITS(8), .WRAP(1)) u_d8w (.clk(clk), .reset_n(reset_n), .clear(clear),
    .load(load), .load_val(lv8), .hold(hold), .up(up), .down(down), .count(c8w),
    .at_max(mx8w), .at_min(mn8w), .wrap_tick(wt8w), .sat(st8w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit bcd_ok(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Sticky record of any illegal nibble on any instance at any cycle.
  always @(negedge clk) begin
    if (!bcd_ok(32'(c4s), 4) || !bcd_ok(32'(c4w), 4) || !bcd_ok(32'(c1s), 1) ||
        !bcd_ok(32'(c1w), 1) || !bcd_ok(c8s, 8) || !bcd_ok(c8w, 8))
      bad_bcd = 1'b1;
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; load = 1'b0; hold = 1'b0; up = 1'b0; down = 1'b0;
    lv4 = '0; lv1 = '0; lv8 = '0;

    // Reset state
    #12;
    check("rst_count4", 32'(c4s), 32'h0);
    check("rst_min", 32'(mn4s), 32'h1);
    check("rst_max", 32'(mx4s), 32'h0);
    check("rst_wtick", 32'(wt4w), 32'h0);
    check("rst_sat", 32'(st4s), 32'h0);
    check("rst_count8", c8w, 32'h0);
    tick();
    reset_n = 1'b1;

    // Count up 1234 events
    up = 1'b1;
    repeat (1234) tick();
    up = 1'b0;
    check("up1234_c4s", 32'(c4s), 32'h1234);
    check("up1234_min", 32'(mn4s), 32'h0);
    check("up1234_max", 32'(mx4s), 32'h0);
    check("up1234_sat", 32'(st4s), 32'h0);
    check("up1234_c4w", 32'(c4w), 32'h1234);
    check("up1234_c1s", 32'(c1s), 32'h9);
    check("up1234_sat1s", 32'(st1s), 32'h1);
    check("up1234_c1w", 32'(c1w), 32'h4);
    check("up1234_c8s", c8s, 32'h1234);

    // Clear
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_c4s", 32'(c4s), 32'h0);
    check("clr_sat1s", 32'(st1s), 32'h0);
    check("clr_min", 32'(mn1s), 32'h1);

    // Saturate / wrap at the top
    load = 1'b1; lv4 = 16'h9998; lv1 = 4'h8; lv8 = 32'h99999998;
    tick(); load = 1'b0;
    check("ld_c4s", 32'(c4s), 32'h9998);
    up = 1'b1; tick();
    check("up1_c4s", 32'(c4s), 32'h9999);
    check("up1_max", 32'(mx4s), 32'h1);
    check("up1_sat", 32'(st4s), 32'h0);
    check("up1_c8s", c8s, 32'h99999999);
    check("up1_max8", 32'(mx8s), 32'h1);
    tick();
    check("up2_c4s", 32'(c4s), 32'h9999);
    check("up2_sat", 32'(st4s), 32'h1);
    check("up2_c4w", 32'(c4w), 32'h0);
    check("up2_wt4w", 32'(wt4w), 32'h1);
    check("up2_min4w", 32'(mn4w), 32'h1);
    check("up2_sat4w", 32'(st4w), 32'h0);
    check("up2_c1s", 32'(c1s), 32'h9);
    check("up2_sat1s", 32'(st1s), 32'h1);
    check("up2_c1w", 32'(c1w), 32'h0);
    check("up2_wt1w", 32'(wt1w), 32'h1);
    check("up2_sat8s", 32'(st8s), 32'h1);
    check("up2_c8w", c8w, 32'h0);
    check("up2_wt8w", 32'(wt8w), 32'h1);
    tick();
    check("up3_c4s", 32'(c4s), 32'h9999);
    check("up3_c4w", 32'(c4w), 32'h1);
    check("up3_wt4w", 32'(wt4w), 32'h0);
    check("up3_c1w", 32'(c1w), 32'h1);
    check("up3_c8w", c8w, 32'h1);
    up = 1'b0; down = 1'b1; tick(); down = 1'b0;
    check("dn_c4s", 32'(c4s), 32'h9998);
    check("dn_sat", 32'(st4s), 32'h1);
    check("dn_max", 32'(mx4s), 32'h0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr2_c4s", 32'(c4s), 32'h0);
    check("clr2_sat", 32'(st4s), 32'h0);

    // Wrap both directions from all-9s
    load = 1'b1; lv4 = 16'h9999; lv1 = 4'h9; lv8 = 32'h99999999;
    tick(); load = 1'b0;
    up = 1'b1; tick(); up = 1'b0;
    check("wup_c4w", 32'(c4w), 32'h0);
    check("wup_wt4w", 32'(wt4w), 32'h1);
    check("wup_c8w", c8w, 32'h0);
    down = 1'b1; tick(); down = 1'b0;
    check("wdn_c4w", 32'(c4w), 32'h9999);
    check("wdn_wt4w", 32'(wt4w), 32'h1);
    check("wdn_max4w", 32'(mx4w), 32'h1);
    check("wdn_c1w", 32'(c1w), 32'h9);
    check("wdn_c8w", c8w, 32'h99999999);
    check("wdn_wt8w", 32'(wt8w), 32'h1);
    tick();
    check("widle_wt4w", 32'(wt4w), 32'h0);
    check("widle_c4w", 32'(c4w), 32'h9999);

    // Saturate / wrap at the bottom
    clear = 1'b1; tick(); clear = 1'b0;
    down = 1'b1; tick(); down = 1'b0;
    check("zdn_c4s", 32'(c4s), 32'h0);
    check("zdn_sat4s", 32'(st4s), 32'h1);
    check("zdn_min4s", 32'(mn4s), 32'h1);
    check("zdn_sat1s", 32'(st1s), 32'h1);
    check("zdn_c8s", c8s, 32'h0);
    check("zdn_sat8s", 32'(st8s), 32'h1);
    check("zdn_c4w", 32'(c4w), 32'h9999);
    check("zdn_c1w", 32'(c1w), 32'h9);

    // Borrow chain, load keeps sat, priority
    load = 1'b1; lv4 = 16'h1000; tick(); load = 1'b0;
    check("ld1000_sat", 32'(st4s), 32'h1);
    down = 1'b1; tick();
    check("borrow_c4s", 32'(c4s), 32'h0999);
    up = 1'b1; tick();
    check("updn_c4s", 32'(c4s), 32'h0999);
    check("updn_wt4w", 32'(wt4w), 32'h0);
    down = 1'b0; hold = 1'b1; tick();
    check("hold_c4s", 32'(c4s), 32'h0999);
    hold = 1'b0; up = 1'b0;
    clear = 1'b1; load = 1'b1; lv4 = 16'h1234; tick(); clear = 1'b0; load = 1'b0;
    check("clrld_c4s", 32'(c4s), 32'h0);
    check("clrld_sat", 32'(st4s), 32'h0);
    check("clrld_min", 32'(mn4s), 32'h1);

    // Invalid nibbles clamp to 9
    load = 1'b1; lv4 = 16'hA3F7; lv1 = 4'hF; lv8 = 32'hFA3F7C12; tick(); load = 1'b0;
    check("inv_c4s", 32'(c4s), 32'h9397);
    check("inv_c1s", 32'(c1s), 32'h9);
    check("inv_max1s", 32'(mx1s), 32'h1);
    check("inv_c8s", c8s, 32'h99397912);

    // Async reset mid-count
    up = 1'b1; tick(); tick();
    check("pre_rst_c4s", 32'(c4s), 32'h9399);
    reset_n = 1'b0; #2;
    check("arst_c4s", 32'(c4s), 32'h0);
    check("arst_min", 32'(mn4s), 32'h1);
    check("arst_c8s", c8s, 32'h0);
    #2; reset_n = 1'b1;
    tick(); up = 1'b0;
    check("resume_c4s", 32'(c4s), 32'h1);
    check("resume_min", 32'(mn4s), 32'h0);

    check("no_bad_nibble", 32'(bad_bcd), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised N-digit BCD event counter for the sequence-detector display path. It counts single-cycle increment or decrement events into a packed BCD value that drives the 7-segment multiplexer directly. It extends the fixed 4-digit up-only counter with:
- configurable digit count;
- up/down counting;
- selectable saturate or wrap-around at the limits;
- synchronous clear, parallel load and hold;
- status flags.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
- WRAP, 0, 0 = saturate at limits, 1 = wrap around at limits.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset: one clock; reset is asynchronous and active-low.
- clear  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  4*DIGITS  packed BCD load value; digit i at bits [4i+3:4i].
- hold  in  1  freeze count (blocks up/down only).
- up  in  1  increment event, one count per cycle high.
- down  in  1  decrement event, one count per cycle high.
- count  out  4*DIGITS  packed BCD count, registered.
- at_max  out  1  count is all 9s, registered.
- at_min  out  1  count is all 0s, registered.
- wrap_tick  out  1  one-cycle pulse on a wrap event, registered.
- sat  out  1  sticky: an event was dropped at a limit.

## Operation
Per-cycle priority, highest first: clear, load, hold, up/down.

clear:
- count = 0, sat = 0, wrap_tick = 0.

load:
- count = load_val. Any nibble > 9 is loaded as 9.
- sat unchanged; wrap_tick = 0.

hold, or up and down both high:
- No count change; wrap_tick = 0.

up only:
- Ripple increment. A digit at 9 becomes 0 and carries into the next digit.
- At all-9s with WRAP=0: count unchanged, sat = 1.
- At all-9s with WRAP=1: count = 0, wrap_tick = 1.

down only:
- Ripple decrement. A digit at 0 becomes 9 and borrows from the next digit.
- At all-0s with WRAP=0: count unchanged, sat = 1.
- At all-0s with WRAP=1: count = all 9s, wrap_tick = 1.

General rules:
- No digit ever holds a value > 9.
- There is no stop state; counting continues after saturation.
- sat clears only on clear or reset.
- at_max and at_min are computed from the next count and registered with it, so they always agree with count.

## Timing
- Reset values: count = 0, at_min = 1, at_max = 0, wrap_tick = 0, sat = 0.
- Latency: inputs are sampled on the rising edge of clk and take effect on count in the same edge (1 cycle).
- up held high for K cycles gives K counts. Edge detection and debouncing are upstream.
- wrap_tick is high for exactly the cycle following the wrapping edge.
- Asserting reset_n low mid-count clears everything immediately; counting resumes on the first rising edge after release.
- Carry/borrow across all digits resolves combinationally within one cycle.

## Structure
- Shared package (display_pkg):
  - BCD_MAX = 4'd9;
  - digit typedef (4-bit);
  - mode constants MODE_SAT = 0, MODE_WRAP = 1.
- Sub-module bcd_digit: one digit with inc, dec, carry_in/borrow_in, carry_out/borrow_out and a next-value output.
- Top level instantiates DIGITS copies with a generate loop and holds all registers and flag logic.

## Test plan
- Reset and count-up (DIGITS=4): reset_n low then high, up high for 1234 cycles -> count = 0x1234, at_min = 0, sat = 0.
- Saturate (WRAP=0): load 0x9998, then 3 up pulses -> count = 0x9999, at_max = 1, sat = 1; then 1 down pulse -> count = 0x9998, sat stays 1; clear -> count = 0, sat = 0.
- Wrap both directions (WRAP=1):
  - load 0x9999, 1 up -> count = 0x0000 with a one-cycle wrap_tick;
  - 1 down -> count = 0x9999 with a one-cycle wrap_tick.
- Borrow chain and priority:
  - load 0x1000, 1 down -> count = 0x0999;
  - up and down both high -> count unchanged;
  - hold with up high -> count unchanged;
  - clear and load together -> count = 0.
- Invalid load and async reset:
  - load_val 0xA3F7 -> count = 0x9397;
  - reset_n low mid-count between clock edges -> count = 0 before the next edge.
- Parameter sweep: DIGITS=1 and DIGITS=8 runs checking the wrap and saturate limits 9 and 99999999, with no nibble > 9 at any cycle.
